// File: rtl/crypto_pkg.sv
// rtl/crypto_pkg.sv - shared constants, key schedule and round functions for the 16-bit Feistel cipher
package crypto_pkg;

  localparam logic [15:0] KEY_DEFAULT = 16'hABCD;
  localparam int          ROUNDS      = 8;

  // One 16-bit subkey per round, index 0 is the first encryption round.
  typedef logic [ROUNDS-1:0][15:0] round_keys_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } dec_state_t;

  // Xorshift-style expansion of the cipher key; purely constant for a given key.
  function automatic round_keys_t key_schedule(input logic [15:0] key);
    logic [15:0] seed;
    round_keys_t keys;
    seed = key;
    keys = '0;
    for (int i = 0; i < ROUNDS; i++) begin
      seed = seed ^ (seed << 7);
      seed = seed ^ (seed >> 9);
      seed = seed ^ (seed << 8);
      keys[i] = seed;
    end
    return keys;
  endfunction

  // Round function: mix the half-block with the low key byte, offset by the high key byte.
  function automatic logic [7:0] round_f(input logic [7:0] x, input logic [15:0] k);
    logic [7:0] mixed;
    mixed = x ^ k[7:0];
    return mixed + k[15:8];
  endfunction

  // Forward round used by the encryption path: {L,R} -> {R, L ^ F(R,k)}.
  function automatic logic [15:0] fwd_round(input logic [15:0] blk, input logic [15:0] k);
    return {blk[7:0], blk[15:8] ^ round_f(blk[7:0], k)};
  endfunction

  // Inverse round: {L',R'} -> {R' ^ F(L',k), L'}; undoes fwd_round with the same key.
  function automatic logic [15:0] inv_round(input logic [15:0] blk, input logic [15:0] k);
    return {blk[7:0] ^ round_f(blk[15:8], k), blk[15:8]};
  endfunction

endpackage

// File: rtl/feistel_inv_round.sv
// rtl/feistel_inv_round.sv - combinational single inverse Feistel round
module feistel_inv_round
  import crypto_pkg::*;
(
  input  logic [15:0] blk_cur,
  input  logic [15:0] round_key,
  output logic [15:0] blk_next
);

  // The left half of the incoming block is the right half of the previous round's input.
  assign blk_next = inv_round(blk_cur, round_key);

endmodule

// File: rtl/crypto_decrypt_iter.sv
// rtl/crypto_decrypt_iter.sv - iterative one-round-per-cycle Feistel decryptor with valid/ready ports
module crypto_decrypt_iter
  import crypto_pkg::*;
#(
  parameter logic [15:0] KEY    = KEY_DEFAULT,
  parameter int          ROUNDS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        busy
);

  // Subkeys are fixed at elaboration; decryption walks them from last to first.
  localparam round_keys_t RKEYS     = key_schedule(KEY);
  localparam logic [2:0]  RND_FIRST = 3'(ROUNDS - 1);

  dec_state_t  state;
  logic [15:0] state_reg;
  logic [2:0]  rnd;
  logic [15:0] round_out;

  feistel_inv_round u_round (
    .blk_cur   (state_reg),
    .round_key (RKEYS[rnd]),
    .blk_next  (round_out)
  );

  // FSM, round counter, data register and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      state_reg <= '0;
      rnd       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            state_reg <= in_data;
            rnd       <= RND_FIRST;
            state     <= ST_RUN;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
          end
        end
        ST_RUN: begin
          state_reg <= round_out;
          rnd       <= rnd - 3'd1;
          // Leaving on rnd==0 keeps the counter from ever wrapping.
          if (rnd == 3'd0) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
            out_data  <= round_out;
          end
        end
        ST_DONE: begin
          // in_ready rises after this edge, so a new word cannot be taken on the handshake edge.
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
          out_data  <= '0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crypto_decrypt_iter.sv
// tb/tb_crypto_decrypt_iter.sv - scoreboard testbench for crypto_decrypt_iter
module tb_crypto_decrypt_iter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [15:0] in_data, out_data;
  logic        in_valid0, in_ready0, out_valid0, out_ready0, busy0;
  logic [15:0] in_data0, out_data0;

  crypto_decrypt_iter #(.KEY(16'hABCD), .ROUNDS(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  crypto_decrypt_iter #(.KEY(16'h0000), .ROUNDS(8)) dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
    .busy(busy0)
  );

  int checks   = 0;
  int failures = 0;
  logic [15:0] sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference key schedule written with plain unsigned arithmetic.
  function automatic int unsigned model_key(input int unsigned key, input int idx);
    int unsigned s;
    s = key & 32'hFFFF;
    for (int j = 0; j <= idx; j++) begin
      s = (s ^ (s << 7)) & 32'hFFFF;
      s = s ^ (s >> 9);
      s = (s ^ (s << 8)) & 32'hFFFF;
    end
    return s;
  endfunction

  // Reference encryption: eight forward rounds with keys K0..K7.
  function automatic logic [15:0] model_encrypt(input int unsigned key, input int unsigned x);
    int unsigned l, r, t, k, f;
    l = (x >> 8) & 255;
    r = x & 255;
    for (int i = 0; i < 8; i++) begin
      k = model_key(key, i);
      f = ((r ^ (k & 255)) + (k >> 8)) % 256;
      t = l ^ f;
      l = r;
      r = t;
    end
    return 16'((l << 8) | r);
  endfunction

  // Monitor: every output handshake is compared against the oldest expected plaintext.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) check("sb_unexpected_output", {16'h0, out_data}, 32'hFFFF_FFFF);
        else check("sb_data", {16'h0, out_data}, {16'h0, sb_q.pop_front()});
      end
      if (!out_valid) check("bus_zero_when_invalid", {16'h0, out_data}, 32'h0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // Offer one word and hold it until accepted; optionally record the expected plaintext.
  task automatic send(input logic [15:0] cipher, input logic [15:0] plain, input bit push);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = cipher;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    check("send_accept", {31'h0, in_ready}, 32'h1);
    if (push) sb_q.push_back(plain);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  // Key-zero instance: directed latency and result check.
  task automatic run0(input logic [15:0] w, input logic [15:0] exp);
    int lat;
    lat = 0;
    in_valid0 = 1'b1;
    in_data0  = w;
    @(posedge clk);
    #1;
    in_valid0 = 1'b0;
    while (!out_valid0 && lat < 30) begin
      check("k0_in_ready_low_run", {31'h0, in_ready0}, 32'h0);
      check("k0_busy_run", {31'h0, busy0}, 32'h1);
      @(posedge clk);
      #1;
      lat++;
    end
    check("k0_latency", lat, 8);
    check("k0_data", {16'h0, out_data0}, {16'h0, exp});
    check("k0_in_ready_low_done", {31'h0, in_ready0}, 32'h0);
    @(posedge clk);
    #1;
    check("k0_out_valid_drop", {31'h0, out_valid0}, 32'h0);
    check("k0_in_ready_back", {31'h0, in_ready0}, 32'h1);
  endtask

  initial begin
    logic [15:0] x, x2, held;
    logic [15:0] corners [3];
    int lat, k;
    time t1, t2;
    corners[0] = 16'h0000;
    corners[1] = 16'hFFFF;
    corners[2] = 16'h8001;

    rst = 1'b1;
    in_valid = 1'b0;  in_data = '0;  out_ready = 1'b0;
    in_valid0 = 1'b0; in_data0 = '0; out_ready0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'h0, in_ready}, 32'h1);
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_out_data", {16'h0, out_data}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_k0_in_ready", {31'h0, in_ready0}, 32'h1);
    check("rst_k0_busy", {31'h0, busy0}, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Key zero: all subkeys are zero, result is fixed by the swap structure.
    out_ready0 = 1'b1;
    run0(16'h0101, 16'h0100);
    run0(16'h0000, 16'h0000);
    check("model_k0_encrypt", {16'h0, model_encrypt(0, 16'h0100)}, 32'h0101);

    // Default key, random and corner plaintexts with random output stalls.
    for (int i = 0; i < 259; i++) begin
      x = (i < 256) ? 16'($urandom) : corners[i - 256];
      out_ready = 1'b0;
      send(model_encrypt(16'hABCD, x), x, 1'b1);
      wait_valid(lat);
      check("latency", lat, 8);
      k = $urandom_range(0, 3);
      repeat (k) begin
        @(posedge clk);
        #1;
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("handshake_ready_back", {31'h0, in_ready}, 32'h1);
      check("handshake_valid_drop", {31'h0, out_valid}, 32'h0);
    end

    // Backpressure: result held 20 cycles while extra input is offered.
    out_ready = 1'b0;
    x = 16'($urandom);
    send(model_encrypt(16'hABCD, x), x, 1'b1);
    wait_valid(lat);
    check("bp_latency", lat, 8);
    held = out_data;
    check("bp_data", {16'h0, held}, {16'h0, x});
    for (int c = 0; c < 20; c++) begin
      in_valid = 1'b1;
      in_data  = 16'($urandom);
      @(posedge clk);
      #1;
      check("bp_valid_hold", {31'h0, out_valid}, 32'h1);
      check("bp_data_hold", {16'h0, out_data}, {16'h0, held});
      check("bp_in_ready_low", {31'h0, in_ready}, 32'h0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", {31'h0, out_valid}, 32'h0);
    check("bp_release_ready", {31'h0, in_ready}, 32'h1);
    check("bp_release_busy", {31'h0, busy}, 32'h0);

    // Asynchronous reset between edges after four rounds.
    x = 16'($urandom);
    send(model_encrypt(16'hABCD, x), x, 1'b0);
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_out_valid", {31'h0, out_valid}, 32'h0);
    check("arst_out_data", {16'h0, out_data}, 32'h0);
    check("arst_busy", {31'h0, busy}, 32'h0);
    check("arst_in_ready", {31'h0, in_ready}, 32'h1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    x = 16'($urandom);
    send(model_encrypt(16'hABCD, x), x, 1'b1);
    wait_valid(lat);
    check("arst_after_latency", lat, 8);
    @(posedge clk);
    #1;

    // Back-to-back with in_valid held high across two words.
    out_ready = 1'b1;
    x  = 16'($urandom);
    x2 = 16'($urandom);
    in_valid = 1'b1;
    in_data  = model_encrypt(16'hABCD, x);
    k = 0;
    do begin @(negedge clk); k++; end while (!in_ready && k < 200);
    sb_q.push_back(x);
    @(posedge clk);
    t1 = $time;
    #1;
    in_data = model_encrypt(16'hABCD, x2);
    k = 0;
    do begin @(negedge clk); k++; end while (!in_ready && k < 200);
    check("b2b_second_accept", {31'h0, in_ready}, 32'h1);
    sb_q.push_back(x2);
    @(posedge clk);
    t2 = $time;
    #1;
    in_valid = 1'b0;
    check("b2b_spacing", 32'((t2 - t1) / 10), 32'd10);
    wait_valid(lat);
    check("b2b_latency", lat, 8);
    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/crypto_decrypt_iter.md
Name: crypto_decrypt_iter

Overview:
- Iterative, multi-cycle Feistel decryptor. Exact inverse of the team's 8-round 16-bit Feistel encryption path: D(E(x)) = x for every x and key.
- Processes one inverse round per clock, which lowers area and toggle energy relative to an unrolled core.
- Sits on the CPU coprocessor bus behind a valid/ready handshake on both input and output.

Parameters:
- KEY, 16'hABCD, 16-bit cipher key. Must equal the key used by the encryption path.
- ROUNDS, 8, number of Feistel rounds. Fixed at 8; other values are unsupported.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  ciphertext word offered.
- in_ready  output  1  block can accept a ciphertext word.
- in_data  input  16  ciphertext.
- out_valid  output  1  plaintext result available.
- out_ready  input  1  consumer accepts the result.
- out_data  output  16  plaintext.
- busy  output  1  high while in RUN or DONE.

Behaviour:
- Key schedule is constant, derived from KEY. All arithmetic is 16-bit with truncation.
  - seed = KEY.
  - For i = 0..7: seed ^= seed<<7; seed ^= seed>>9; seed ^= seed<<8; K[i] = seed.
- Round function F(x8, k16) = (x8 ^ k[7:0]) + k[15:8], mod 256.
- Forward (encrypt) round, for reference: {L,R} -> {R, L ^ F(R,k)}. Encryption applies K0..K7 in order.
- Inverse round, implemented here: {L',R'} -> {R' ^ F(L',k), L'}. Decryption applies K7, K6, ..., K0.
- FSM states: IDLE, RUN, DONE. Encoding is free.
  - IDLE: in_ready=1. On in_valid at an edge: state_reg <= in_data; rnd <= 7; go to RUN.
  - RUN: each edge applies the inverse round with K[rnd] to state_reg, then rnd <= rnd-1. The edge that applies K[0] moves to DONE.
  - DONE: out_valid=1 and out_data=state_reg, held stable. On out_ready at an edge, go to IDLE.
- Latency: the accept edge is E0. Rounds are applied on E1..E8. out_valid rises after E8, i.e. 8 cycles after acceptance.
- Throughput: at most one word per 10 cycles with out_ready tied high.
- in_ready is 0 in RUN and DONE. in_valid in those states is ignored; nothing is queued and nothing is dropped silently into state.
- out_ready in IDLE or RUN has no effect.
- out_ready asserted in DONE: the output handshake completes on that edge. in_ready goes to 1 only in the next cycle; there is no same-cycle re-accept.
- rnd is a 3-bit down-counter. Wrap from 0 never occurs because the FSM leaves RUN on rnd==0.
- Reset, asynchronous, at any time including mid-RUN or in DONE: state=IDLE, state_reg=0, rnd=0. Outputs during and after reset: in_ready=1, out_valid=0, out_data=0, busy=0. The partial result is discarded.
- out_data is 0 whenever out_valid is 0 (registered mux). This gives a clean bus and no leakage of intermediate rounds.
- busy = (state != IDLE).
- No combinational path from in_valid/out_ready to any output.

Decomposition:
- Shared package crypto_pkg holds:
  - KEY_DEFAULT = 16'hABCD.
  - ROUNDS = 8.
  - Key-schedule function returning K[0..7].
  - Round function F(x8, k16).
- The encryption path and this block both use the package, so the two cannot diverge.
- One natural sub-module: feistel_inv_round, purely combinational, 16-bit data in, 16-bit key in, 16-bit data out.
- FSM, counter and registers live in crypto_decrypt_iter.

Test Plan:
- KEY=16'h0000 (all K=0), in_data=16'h0101, out_ready=1 -> out_valid exactly 8 cycles after accept; out_data=16'h0100; in_ready low during RUN/DONE.
- KEY=16'h0000, in_data=16'h0000 -> out_data=16'h0000. Bench model check: encrypting 16'h0100 with the key-0 schedule gives 16'h0101.
- Default KEY, 256 random x plus 0x0000/0xFFFF/0x8001: bench encrypts x with the package model, feeds E(x) -> out_data == x for all.
- Backpressure: out_ready=0 for 20 cycles after result -> out_valid and out_data stable, in_ready=0, extra in_valid ignored. Then raise out_ready -> handshake, in_ready=1 one cycle later.
- Async reset asserted mid-RUN (after 4 rounds), between clock edges -> immediately out_valid=0, out_data=0, busy=0, in_ready=1. After release, a new word decrypts correctly with full 8-cycle latency.
- Back-to-back: in_valid held high with two words, out_ready=1 -> second accepted 10 cycles after the first; both results correct, in order.
